// File: rtl/fractal_sync_mp_req_fe.sv
// Multi-port request front end for the fractal sync CAM: per-port request FIFOs,
// lowest-index collision arbitration on equal signatures, and registered check-hit responses.
package fractal_sync_pkg;
  localparam int unsigned SD_WIDTH = 2;
endpackage

module fractal_sync_mp_req_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
)(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           cnt;

  assign empty_o = (cnt == '0);
  assign full_o  = (cnt == CW'(DEPTH));
  assign data_o  = mem[rd_ptr];

  // Callers guarantee push only when !full and pop only when !empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_i) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_i)
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module fractal_sync_mp_req_fe #(
  parameter  int unsigned N_PORTS    = 2,
  parameter  int unsigned LVL_WIDTH  = 4,
  parameter  int unsigned ID_WIDTH   = 4,
  parameter  int unsigned FIFO_DEPTH = 2,
  localparam int unsigned SIG_WIDTH  = LVL_WIDTH + ID_WIDTH,
  localparam int unsigned SD_WIDTH   = fractal_sync_pkg::SD_WIDTH
)(
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [N_PORTS-1:0]                  req_valid_i,
  output logic [N_PORTS-1:0]                  req_ready_o,
  input  logic [N_PORTS-1:0]                  req_set_i,
  input  logic [N_PORTS-1:0][LVL_WIDTH-1:0]   req_level_i,
  input  logic [N_PORTS-1:0][ID_WIDTH-1:0]    req_id_i,
  input  logic [N_PORTS-1:0][SD_WIDTH-1:0]    req_sd_i,
  output logic [N_PORTS-1:0]                  cam_check_o,
  output logic [N_PORTS-1:0]                  cam_set_o,
  output logic [N_PORTS-1:0][SIG_WIDTH-1:0]   cam_sig_o,
  output logic [N_PORTS-1:0]                  cam_sig_valid_o,
  output logic [N_PORTS-1:0][SD_WIDTH-1:0]    cam_sd_o,
  input  logic [N_PORTS-1:0]                  cam_present_i,
  input  logic [N_PORTS-1:0][SD_WIDTH-1:0]    cam_sd_i,
  output logic [N_PORTS-1:0]                  rsp_valid_o,
  input  logic [N_PORTS-1:0]                  rsp_ready_i,
  output logic [N_PORTS-1:0][LVL_WIDTH-1:0]   rsp_level_o,
  output logic [N_PORTS-1:0][ID_WIDTH-1:0]    rsp_id_o,
  output logic [N_PORTS-1:0][SD_WIDTH-1:0]    rsp_sd_o
);
  typedef struct packed {
    logic                 set;
    logic [LVL_WIDTH-1:0] level;
    logic [ID_WIDTH-1:0]  id;
    logic [SD_WIDTH-1:0]  sd;
  } req_t;

  localparam int unsigned REQ_W = $bits(req_t);

  req_t [N_PORTS-1:0]                head;
  logic [N_PORTS-1:0][SIG_WIDTH-1:0] sig;
  logic [N_PORTS-1:0]                empty, full, slot_free, elig, collision, issue, push;

  // Collision only looks at eligibility, never at cam_present_i, so there is no loop through the CAM.
  always_comb begin
    collision = '0;
    for (int p = 1; p < N_PORTS; p++)
      for (int q = 0; q < p; q++)
        if (elig[q] && sig[q] == sig[p]) collision[p] = 1'b1;
  end

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    req_t req_in, head_raw;

    assign req_in = '{set: req_set_i[p], level: req_level_i[p], id: req_id_i[p], sd: req_sd_i[p]};
    assign push[p]        = req_valid_i[p] & ~full[p];
    assign req_ready_o[p] = ~full[p];

    fractal_sync_mp_req_fifo #(.W(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push[p]),
      .data_i  (req_in),
      .pop_i   (issue[p]),
      .data_o  (head_raw),
      .empty_o (empty[p]),
      .full_o  (full[p])
    );

    assign head[p]      = head_raw;
    assign sig[p]       = {head_raw.level, head_raw.id};
    assign slot_free[p] = ~rsp_valid_o[p] | rsp_ready_i[p];
    assign elig[p]      = ~empty[p] & slot_free[p];
    assign issue[p]     = elig[p] & ~collision[p];

    assign cam_sig_valid_o[p] = issue[p];
    assign cam_check_o[p]     = issue[p] & ~head_raw.set;
    assign cam_set_o[p]       = issue[p] & head_raw.set;
    assign cam_sig_o[p]       = issue[p] ? sig[p] : '0;
    assign cam_sd_o[p]        = issue[p] ? head_raw.sd : '0;

    // Reload on a check hit takes priority over the consumer's clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rsp_valid_o[p] <= 1'b0;
        rsp_level_o[p] <= '0;
        rsp_id_o[p]    <= '0;
        rsp_sd_o[p]    <= '0;
      end else if (issue[p] && !head_raw.set && cam_present_i[p]) begin
        rsp_valid_o[p] <= 1'b1;
        rsp_level_o[p] <= head_raw.level;
        rsp_id_o[p]    <= head_raw.id;
        rsp_sd_o[p]    <= head_raw.sd | cam_sd_i[p];
      end else if (rsp_ready_i[p]) begin
        rsp_valid_o[p] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fractal_sync_mp_req_fe.sv
// Directed bench for fractal_sync_mp_req_fe: the CAM is played by hand-set cam_present_i/cam_sd_i.
module tb_fractal_sync_mp_req_fe;
  localparam int unsigned NP = 2;
  localparam int unsigned LW = 4;
  localparam int unsigned IW = 4;
  localparam int unsigned SW = 8;
  localparam int unsigned DW = 2;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [NP-1:0]         req_valid_i, req_ready_o, req_set_i;
  logic [NP-1:0][LW-1:0] req_level_i;
  logic [NP-1:0][IW-1:0] req_id_i;
  logic [NP-1:0][DW-1:0] req_sd_i;
  logic [NP-1:0]         cam_check_o, cam_set_o, cam_sig_valid_o;
  logic [NP-1:0][SW-1:0] cam_sig_o;
  logic [NP-1:0][DW-1:0] cam_sd_o;
  logic [NP-1:0]         cam_present_i;
  logic [NP-1:0][DW-1:0] cam_sd_i;
  logic [NP-1:0]         rsp_valid_o, rsp_ready_i;
  logic [NP-1:0][LW-1:0] rsp_level_o;
  logic [NP-1:0][IW-1:0] rsp_id_o;
  logic [NP-1:0][DW-1:0] rsp_sd_o;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  fractal_sync_mp_req_fe #(.N_PORTS(NP), .LVL_WIDTH(LW), .ID_WIDTH(IW), .FIFO_DEPTH(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_set_i(req_set_i),
    .req_level_i(req_level_i), .req_id_i(req_id_i), .req_sd_i(req_sd_i),
    .cam_check_o(cam_check_o), .cam_set_o(cam_set_o), .cam_sig_o(cam_sig_o),
    .cam_sig_valid_o(cam_sig_valid_o), .cam_sd_o(cam_sd_o),
    .cam_present_i(cam_present_i), .cam_sd_i(cam_sd_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_level_o(rsp_level_o), .rsp_id_o(rsp_id_o), .rsp_sd_o(rsp_sd_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic push(input int p, input logic s, input logic [3:0] lvl, input logic [3:0] id,
                      input logic [1:0] sd);
    req_valid_i[p] = 1'b1;
    req_set_i[p]   = s;
    req_level_i[p] = lvl;
    req_id_i[p]    = id;
    req_sd_i[p]    = sd;
  endtask

  initial begin
    rst_ni = 1'b0;
    req_valid_i = '0; req_set_i = '0; req_level_i = '0; req_id_i = '0; req_sd_i = '0;
    cam_present_i = '0; cam_sd_i = '0; rsp_ready_i = '1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", 32'(req_ready_o), 32'h3);
    chk("rst_rspv", 32'(rsp_valid_o), 32'h0);
    chk("rst_camv", 32'(cam_sig_valid_o), 32'h0);
    chk("rst_rsp_sd", 32'(rsp_sd_o), 32'h0);
    step(); rst_ni = 1'b1;

    // check miss, then check hit merging sd
    push(0, 1'b0, 4'd1, 4'd3, 2'b10);
    @(negedge clk_i);
    chk("no_bypass", 32'(cam_sig_valid_o), 32'h0);
    step(); req_valid_i = '0;
    @(negedge clk_i);
    chk("miss_check", 32'(cam_check_o), 32'h1);
    chk("miss_set", 32'(cam_set_o), 32'h0);
    chk("miss_sig", 32'(cam_sig_o[0]), 32'h13);
    chk("miss_sd", 32'(cam_sd_o[0]), 32'h2);
    step();
    @(negedge clk_i);
    chk("miss_idle", 32'(cam_sig_valid_o), 32'h0);
    chk("miss_norsp", 32'(rsp_valid_o), 32'h0);
    push(0, 1'b0, 4'd1, 4'd3, 2'b10);
    step(); req_valid_i = '0; cam_present_i[0] = 1'b1; cam_sd_i[0] = 2'b01;
    @(negedge clk_i);
    chk("hit_check", 32'(cam_check_o), 32'h1);
    step(); cam_present_i = '0;
    @(negedge clk_i);
    chk("hit_rspv", 32'(rsp_valid_o), 32'h1);
    chk("hit_sd", 32'(rsp_sd_o[0]), 32'h3);
    chk("hit_lvl", 32'(rsp_level_o[0]), 32'h1);
    chk("hit_id", 32'(rsp_id_o[0]), 32'h3);
    step();
    @(negedge clk_i);
    chk("hit_clr", 32'(rsp_valid_o), 32'h0);

    // set with CAM hit produces no response
    push(0, 1'b1, 4'd2, 4'd5, 2'b01);
    step(); req_valid_i = '0; cam_present_i[0] = 1'b1; cam_sd_i[0] = 2'b10;
    @(negedge clk_i);
    chk("set_set", 32'(cam_set_o), 32'h1);
    chk("set_check", 32'(cam_check_o), 32'h0);
    chk("set_sig", 32'(cam_sig_o[0]), 32'h25);
    step(); cam_present_i = '0;
    @(negedge clk_i);
    chk("set_norsp", 32'(rsp_valid_o), 32'h0);

    // same-signature collision: port 0 first, port 1 next cycle
    push(0, 1'b0, 4'd2, 4'd1, 2'b01);
    push(1, 1'b0, 4'd2, 4'd1, 2'b10);
    step(); req_valid_i = '0;
    @(negedge clk_i);
    chk("col_first", 32'(cam_sig_valid_o), 32'h1);
    chk("col_sig0", 32'(cam_sig_o[0]), 32'h21);
    step();
    @(negedge clk_i);
    chk("col_second", 32'(cam_sig_valid_o), 32'h2);
    chk("col_sig1", 32'(cam_sig_o[1]), 32'h21);
    chk("col_sd1", 32'(cam_sd_o[1]), 32'h2);
    step();
    @(negedge clk_i);
    chk("col_idle", 32'(cam_sig_valid_o), 32'h0);

    // backpressure on port 0, then back-to-back hits while draining
    rsp_ready_i[0] = 1'b0;
    push(0, 1'b0, 4'd3, 4'd1, 2'b10);
    step(); req_valid_i = '0; cam_present_i[0] = 1'b1; cam_sd_i[0] = 2'b01;
    @(negedge clk_i);
    chk("bp_issue", 32'(cam_check_o), 32'h1);
    step(); cam_present_i = '0; push(0, 1'b0, 4'd3, 4'd2, 2'b10);
    @(negedge clk_i);
    chk("bp_rspv", 32'(rsp_valid_o), 32'h1);
    step(); push(0, 1'b0, 4'd3, 4'd3, 2'b10);
    @(negedge clk_i);
    chk("bp_stall1", 32'(cam_sig_valid_o), 32'h0);
    chk("bp_ready1", 32'(req_ready_o), 32'h3);
    step(); req_valid_i = '0;
    @(negedge clk_i);
    chk("bp_full", 32'(req_ready_o), 32'h2);
    chk("bp_stall2", 32'(cam_sig_valid_o), 32'h0);
    chk("bp_hold_id", 32'(rsp_id_o[0]), 32'h1);
    step(); rsp_ready_i[0] = 1'b1; cam_present_i[0] = 1'b1; cam_sd_i[0] = 2'b01;
    @(negedge clk_i);
    chk("drain_sig2", 32'(cam_sig_o[0]), 32'h32);
    chk("drain_full", 32'(req_ready_o), 32'h2);
    step();
    @(negedge clk_i);
    chk("drain_ready", 32'(req_ready_o), 32'h3);
    chk("drain_sig3", 32'(cam_sig_o[0]), 32'h33);
    chk("b2b_v1", 32'(rsp_valid_o), 32'h1);
    chk("b2b_id2", 32'(rsp_id_o[0]), 32'h2);
    step(); cam_present_i = '0;
    @(negedge clk_i);
    chk("b2b_v2", 32'(rsp_valid_o), 32'h1);
    chk("b2b_id3", 32'(rsp_id_o[0]), 32'h3);
    chk("b2b_sd", 32'(rsp_sd_o[0]), 32'h3);
    chk("drain_idle", 32'(cam_sig_valid_o), 32'h0);
    step();
    @(negedge clk_i);
    chk("b2b_clr", 32'(rsp_valid_o), 32'h0);

    // reset while port 1 is full with a pending response
    rsp_ready_i[1] = 1'b0;
    push(1, 1'b0, 4'd4, 4'd1, 2'b01);
    step(); req_valid_i = '0; cam_present_i[1] = 1'b1; cam_sd_i[1] = 2'b10;
    step(); cam_present_i = '0; push(1, 1'b0, 4'd4, 4'd2, 2'b01);
    step(); push(1, 1'b0, 4'd4, 4'd3, 2'b01);
    step(); req_valid_i = '0;
    @(negedge clk_i);
    chk("pre_full", 32'(req_ready_o), 32'h1);
    chk("pre_rspv", 32'(rsp_valid_o), 32'h2);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_ready", 32'(req_ready_o), 32'h3);
    chk("mid_rspv", 32'(rsp_valid_o), 32'h0);
    chk("mid_lvl", 32'(rsp_level_o), 32'h0);
    chk("mid_sd", 32'(rsp_sd_o), 32'h0);
    chk("mid_camv", 32'(cam_sig_valid_o), 32'h0);
    step(); rst_ni = 1'b1; rsp_ready_i = '1;
    @(negedge clk_i);
    chk("post_ready", 32'(req_ready_o), 32'h3);
    chk("post_camv", 32'(cam_sig_valid_o), 32'h0);
    chk("post_rspv", 32'(rsp_valid_o), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
